// File: rtl/ip_sequencer.sv
// ip_sequencer: fetch/retire controller that owns the Forth core's instruction pointer.
// It fetches the word at IP and presents it to the execute stage. When that word
// retires, it drives the selects of the external next-IP mux (ip_comb) and loads
// ip_result, or the interrupt vector. It also issues return-address pushes for
// CALL and for taken interrupts, and handles halt.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FETCH   | start a read at IP unless halt is asserted
// WAIT    | imem_req high, address held, waiting for imem_ack
// ISSUE   | instr presented (instr_valid), waiting for exec_done
// HALTED  | idle; IP frozen until halt deasserts
module ip_sequencer #(
    parameter int iaddr_width = 10,
    parameter int instr_width = 16,
    parameter int RESET_VEC   = 0,
    parameter int INT_VEC     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [iaddr_width-1:0] imem_addr,
    input  logic                   imem_ack,
    input  logic [instr_width-1:0] imem_data,
    output logic [instr_width-1:0] instr,
    output logic                   instr_valid,
    input  logic                   exec_done,
    input  logic [2:0]             cf_op,
    input  logic [iaddr_width-1:0] cf_imm,
    output logic [iaddr_width-1:0] ip_imm,
    output logic                   ip_imm_sel,
    output logic                   ip_reg_sel,
    output logic                   ip_tos_sel,
    output logic                   ip_skip,
    input  logic [iaddr_width-1:0] ip_result,
    output logic [iaddr_width-1:0] IP,
    output logic                   rpush,
    output logic [iaddr_width-1:0] rpush_data,
    input  logic                   irq,
    output logic                   irq_ack,
    input  logic                   halt
);

    localparam logic [iaddr_width-1:0] L_RESET_VEC = iaddr_width'(RESET_VEC);
    localparam logic [iaddr_width-1:0] L_INT_VEC   = iaddr_width'(INT_VEC);

    localparam logic [2:0] OP_NEXT = 3'd0;
    localparam logic [2:0] OP_JUMP = 3'd1;
    localparam logic [2:0] OP_RET  = 3'd2;
    localparam logic [2:0] OP_EXEC = 3'd3;
    localparam logic [2:0] OP_BRZ  = 3'd4;
    localparam logic [2:0] OP_CALL = 3'd5;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_ISSUE  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t                 r_state;
    logic [iaddr_width-1:0] r_ip;
    logic                   r_ie;
    logic                   r_req;
    logic                   r_valid;
    logic [instr_width-1:0] r_instr;

    logic                   w_retire;
    logic                   w_take;
    logic [iaddr_width-1:0] w_ip_plus1;
    logic                   w_imm_sel;
    logic                   w_reg_sel;
    logic                   w_tos_sel;
    logic                   w_skip;

    // A retire only exists in ISSUE; reset masks it so no push or select leaks out.
    assign w_retire   = (r_state == S_ISSUE) && exec_done && !reset;
    // A CALL never takes the interrupt, so a retire pushes at most one address.
    assign w_take     = w_retire && irq && r_ie && (cf_op != OP_CALL);
    assign w_ip_plus1 = r_ip + {{(iaddr_width-1){1'b0}}, 1'b1};

    // Control-flow op to ip_comb select lines, active only in the retire cycle.
    always_comb begin
        w_imm_sel = 1'b0;
        w_reg_sel = 1'b0;
        w_tos_sel = 1'b0;
        w_skip    = 1'b0;
        if (w_retire) begin
            case (cf_op)
                OP_JUMP: w_imm_sel = 1'b1;
                OP_RET:  w_reg_sel = 1'b1;
                OP_EXEC: begin
                    w_reg_sel = 1'b1;
                    w_tos_sel = 1'b1;
                end
                OP_BRZ: begin
                    w_skip    = 1'b1;
                    w_imm_sel = 1'b1;
                end
                OP_CALL: w_imm_sel = 1'b1;
                default: ;
            endcase
        end
    end

    // Fetch/issue state machine, IP register and interrupt-enable flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ip    <= L_RESET_VEC;
            r_ie    <= 1'b1;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_instr <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (halt) begin
                        r_state <= S_HALTED;
                    end else begin
                        r_req   <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        r_instr <= imem_data;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (exec_done) begin
                        r_valid <= 1'b0;
                        r_state <= S_FETCH;
                        r_ip    <= w_take ? L_INT_VEC : ip_result;
                        // A taken interrupt wins over the RET that would re-enable.
                        if (w_take)
                            r_ie <= 1'b0;
                        else if (cf_op == OP_RET)
                            r_ie <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (!halt)
                        r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_ip;
    assign IP          = r_ip;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign ip_imm      = cf_imm;
    assign ip_imm_sel  = w_imm_sel;
    assign ip_reg_sel  = w_reg_sel;
    assign ip_tos_sel  = w_tos_sel;
    assign ip_skip     = w_skip;
    assign rpush       = w_retire && (w_take || (cf_op == OP_CALL));
    // On an interrupt the saved address is whatever ip_comb would have produced.
    assign rpush_data  = w_take ? ip_result : w_ip_plus1;
    assign irq_ack     = w_take;

endmodule
